// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the 3x3 convolution line scheduler.
package conv_pkg;
    localparam int IMG_WIDTH_DEFAULT = 512;
    localparam int NUM_LINE_BUFS = 4;
    typedef enum logic [1:0] {MODE_BLUR, MODE_EDGE, MODE_SHARPEN, MODE_EMBOSS} conv_mode_e;
    typedef enum logic {IDLE, READ} sched_state_e;
endpackage

// File: rtl/conv_line_scheduler_line_buffer.sv
// line_buffer: one image line of pixels with a registered three-pixel read.
module line_buffer #(
    parameter int WIDTH = 512
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(WIDTH)-1:0]   wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic [$clog2(WIDTH)-1:0]   rd_addr,
    output logic [23:0]                rd_data
);
    localparam int AW = $clog2(WIDTH);
    logic [7:0] mem [WIDTH];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= {mem[rd_addr + AW'(2)], mem[rd_addr + AW'(1)], mem[rd_addr]};
    end
endmodule

// File: rtl/conv_line_scheduler.sv
// conv_line_scheduler: rotates a raster stream through four line buffers and
// emits one 3x3 window per cycle once three full lines are held.
module conv_line_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic        pixel_in_ready,
    input  logic [1:0]  mode_in,
    output logic [71:0] window_out,
    output logic        window_valid,
    output logic [1:0]  mode_out,
    output logic        line_done
);
    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [AW-1:0] LAST_COL = AW'(IMG_WIDTH - 1);
    localparam logic [AW-1:0] LAST_RD = AW'(IMG_WIDTH - 3);

    sched_state_e state, nextState;
    conv_mode_e   modeReg;
    logic [1:0]    wr_buf, rd_buf, selBuf;
    logic [AW-1:0] wr_col, rd_col;
    logic [2:0]    filled;
    logic          accept, lineIn, startRead, endRead;
    logic [23:0]   rdData [NUM_LINE_BUFS];
    logic [71:0]   win;

    assign pixel_in_ready = filled < 3'd4;
    assign accept = pixel_in_valid && pixel_in_ready;
    assign lineIn = accept && wr_col == LAST_COL;
    assign mode_out = modeReg;
    assign window_out = window_valid ? win : '0;

    always_comb begin
        startRead = state == IDLE && filled >= 3'd3;
        endRead = state == READ && rd_col == LAST_RD;
        nextState = startRead ? READ : endRead ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wr_buf <= '0;
            wr_col <= '0;
            rd_buf <= '0;
            rd_col <= '0;
            selBuf <= '0;
            filled <= '0;
            modeReg <= MODE_BLUR;
            window_valid <= 1'b0;
            line_done <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) wr_col <= lineIn ? '0 : wr_col + AW'(1);
            if (lineIn) wr_buf <= wr_buf + 2'd1;
            filled <= filled + {2'b0, lineIn} - {2'b0, endRead};
            rd_col <= (state == READ && !endRead) ? rd_col + AW'(1) : '0;
            if (endRead) rd_buf <= rd_buf + 2'd1;
            // RAM output lags the address by a cycle, so the row select must lag too
            selBuf <= rd_buf;
            if (startRead) modeReg <= conv_mode_e'(mode_in);
            window_valid <= state == READ;
            line_done <= endRead;
        end
    end

    for (genvar g = 0; g < NUM_LINE_BUFS; g++) begin : g_buf
        line_buffer #(.WIDTH(IMG_WIDTH)) u_buf (
            .clk(clk),
            .wr_en(accept && wr_buf == 2'(g)),
            .wr_addr(wr_col),
            .wr_data(pixel_in),
            .rd_addr(rd_col),
            .rd_data(rdData[g])
        );
    end

    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) win[r*24 +: 24] = rdData[selBuf + 2'(r)];
    end
endmodule

// File: doc/conv_line_scheduler.md
# conv_line_scheduler

Line-buffer controller and window sequencer for the 3×3 convolution datapath. It accepts a raster pixel stream and rotates it through four internal line buffers. Once three complete lines are held, it streams 3×3 windows (72 bits, one per cycle) and a line-stable kernel mode into the convolution block. It pulses an interrupt per consumed line so the upstream DMA can refill.

## Interface
- IMG_WIDTH, 512: pixels per line; legal range 4..4096.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pixel_in  in  8  incoming pixel, unsigned.
- pixel_in_valid  in  1  pixel_in valid.
- pixel_in_ready  out  1  pixel accepted when valid && ready.
- mode_in  in  2  requested kernel mode: 0 blur, 1 edge, 2 sharpen, 3 emboss.
- window_out  out  72  3×3 window to convolution inData.
- window_valid  out  1  window_out valid; drives inDataValid.
- mode_out  out  2  kernel mode held for the whole current line; drives modeSelect.
- line_done  out  1  one-cycle pulse when a line buffer is released.

## Operation
- Reset values: pixel_in_ready 1, window_out 0, window_valid 0, mode_out 0, line_done 0.
- Reset clears wr_buf, wr_col, rd_buf, rd_col, filled and state (to IDLE). Buffer RAM contents are not cleared.
- Write side: an accepted pixel is written to buffer wr_buf at address wr_col, then wr_col increments.
  - When wr_col reaches IMG_WIDTH-1 and that pixel is accepted: wr_col wraps to 0, wr_buf increments mod 4, filled increments.
- pixel_in_ready = (filled < 4).
- filled counts complete, unconsumed lines, range 0..4.
  - Simultaneous increment and decrement in one cycle leaves filled unchanged.
- FSM states IDLE and READ.
  - IDLE → READ when filled ≥ 3. On this transition rd_col is set to 0 and mode_in is latched into mode_out.
  - READ: each cycle, buffers rd_buf, rd_buf+1 and rd_buf+2 (mod 4) are read at columns rd_col, rd_col+1 and rd_col+2. The result is registered into window_out with window_valid = 1. rd_col then increments.
  - READ → IDLE on the cycle rd_col = IMG_WIDTH-3. On that edge: rd_buf increments mod 4, filled decrements, line_done pulses.
- Each line produces exactly IMG_WIDTH-2 windows, with no padding.
- Window packing: byte i = window_out[i*8 +: 8], where row r = i/3 and column c = i%3.
  - Row 0 is the oldest line (rd_buf). Column 0 is the leftmost pixel (rd_col).
- mode_in changes during READ have no effect until the next READ entry.
- Reads never target buffer wr_buf while filled ≤ 3. This is guaranteed by the ready rule.
- The block has no downstream backpressure; the convolution consumes one window per cycle.

## Timing
- Let edge E be the one that accepts the last pixel of the third buffered line.
  - filled = 3 after E.
  - READ is entered at E+1.
  - The first window_valid is high after E+2.
- Windows are back-to-back: IMG_WIDTH-2 consecutive valid cycles.
- The last window_valid and line_done are high in the same cycle.
- After READ exits, IDLE lasts exactly one cycle before re-entering READ if filled ≥ 3 still holds.
- Writes continue during READ. pixel_in_ready drops in the cycle after filled reaches 4. It rises in the cycle after the decrement.
- Asserting rst_n low mid-READ forces window_valid and line_done low immediately. No partial line is resumed.
- Throughput bound: one window per pixel in steady state minus the 3-cycle per-line overhead. Upstream sees backpressure only when it runs ahead by 4 lines.

## Structure
- conv_pkg holds:
  - IMG_WIDTH default.
  - conv_mode_e enum (MODE_BLUR, MODE_EDGE, MODE_SHARPEN, MODE_EMBOSS).
  - sched_state_e (IDLE, READ).
  - The NUM_LINE_BUFS = 4 constant.
- Sub-module line_buffer, instantiated 4×:
  - Parameter WIDTH.
  - Inputs: clk, wr_en, wr_addr, wr_data[7:0], rd_addr.
  - Output: rd_data[23:0], pixels rd_addr..rd_addr+2, registered (1-cycle read latency).
- Counter widths are $clog2(IMG_WIDTH). rd_buf and wr_buf are 2 bits with natural wrap.

## Test plan
- IMG_WIDTH=8; stream 24 pixels of value (line*16+col) with valid held high → first window_valid at E+2.
  - First window bytes 0..8 = 00,01,02,10,11,12,20,21,22.
  - Six valid windows, then line_done.
- Stream 5 lines with no gaps → pixel_in_ready low only while filled = 4.
  - No pixel lost; all 3 lines' window sets match the golden model.
- mode_in = 1 at READ entry, changed to 3 mid-line → mode_out stays 1 for the whole line; becomes 3 on the next line.
- Buffer wrap: stream 8 lines → rd_buf cycles 0,1,2,3,0,1.
  - Windows remain row-ordered oldest-first across the wrap.
- Pulse rst_n low in the middle of READ → all outputs return to reset values asynchronously.
  - After release, a fresh 3-line stream produces a correct first window.
- Random pixel_in_valid gaps at 50% duty → window contents and counts are identical to the gapless run; line_done count equals lines − 2.
